// File: rtl/arm_cond_pkg.sv
// ARM condition-code definitions and writeback packet fields shared by the result stage and fetch-side branch logic.
// Pure type/constant package: no logic, no latency.
package arm_cond_pkg;

   typedef enum logic [3:0] {
      EQ = 4'b0000,
      NE = 4'b0001,
      CS = 4'b0010,
      CC = 4'b0011,
      MI = 4'b0100,
      PL = 4'b0101,
      VS = 4'b0110,
      VC = 4'b0111,
      HI = 4'b1000,
      LS = 4'b1001,
      GE = 4'b1010,
      LT = 4'b1011,
      GT = 4'b1100,
      LE = 4'b1101,
      AL = 4'b1110,
      NV = 4'b1111
   } cond_e;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Width-independent part of the writeback packet; the stage prepends the M-bit result.
   typedef struct packed {
      logic [3:0] rd;
      logic       reg_write;
      logic       mem_write;
      logic       pcs_src;
      logic       cond_ex;
   } wb_ctl_t;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against NZCV; purely combinational, zero latency.
// No handshake: output follows inputs directly.
module cond_check
   import arm_cond_pkg::*;
(
   input  logic [3:0] i_cond,
   input  logic [3:0] i_flags,
   output logic       o_cond_ex
);

   logic w_n;
   logic w_z;
   logic w_c;
   logic w_v;

   assign w_n = i_flags[FLAG_N];
   assign w_z = i_flags[FLAG_Z];
   assign w_c = i_flags[FLAG_C];
   assign w_v = i_flags[FLAG_V];

   always_comb begin
      o_cond_ex = 1'b1;
      case (cond_e'(i_cond))
         EQ: o_cond_ex = w_z;
         NE: o_cond_ex = !w_z;
         CS: o_cond_ex = w_c;
         CC: o_cond_ex = !w_c;
         MI: o_cond_ex = w_n;
         PL: o_cond_ex = !w_n;
         VS: o_cond_ex = w_v;
         VC: o_cond_ex = !w_v;
         HI: o_cond_ex = w_c && !w_z;
         LS: o_cond_ex = !w_c || w_z;
         GE: o_cond_ex = (w_n == w_v);
         LT: o_cond_ex = (w_n != w_v);
         GT: o_cond_ex = !w_z && (w_n == w_v);
         LE: o_cond_ex = w_z || (w_n != w_v);
         // NV is deliberately treated as always-pass on this core.
         default: o_cond_ex = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_result_stage.sv
// Post-ALU stage: condition check, NZCV update, registered writeback packet; 1 cycle accept-to-output.
// 2-entry skid (output + skid register); in_ready is registered and drops only when the skid entry is full.
module alu_result_stage
   import arm_cond_pkg::*;
#(
   parameter int M = 32
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_in_valid,
   output logic         o_in_ready,
   input  logic [M-1:0] i_result,
   input  logic         i_z,
   input  logic         i_n,
   input  logic         i_v,
   input  logic         i_c,
   input  logic [3:0]   i_cond,
   input  logic [1:0]   i_flag_w,
   input  logic         i_reg_w,
   input  logic         i_mem_w,
   input  logic         i_pcs,
   input  logic [3:0]   i_rd,
   input  logic         i_flush,
   output logic         o_out_valid,
   input  logic         i_out_ready,
   output logic [M-1:0] o_out_result,
   output logic [3:0]   o_out_rd,
   output logic         o_out_reg_write,
   output logic         o_out_mem_write,
   output logic         o_out_pcs_src,
   output logic         o_out_cond_ex,
   output logic [3:0]   o_flags_q
);

   // Result width follows M, so the full packet is assembled here around the shared control fields.
   typedef struct packed {
      logic [M-1:0] result;
      wb_ctl_t      ctl;
   } wb_pkt_t;

   logic    r_out_vld;
   logic    r_skid_vld;
   logic    r_in_rdy;
   wb_pkt_t r_out_pkt;
   wb_pkt_t r_skid_pkt;
   logic [3:0] r_flags;

   logic    w_cond_ex;
   logic    w_acc;
   logic    w_deq;
   wb_pkt_t w_in_pkt;
   logic    w_out_vld_nxt;
   logic    w_skid_vld_nxt;
   wb_pkt_t w_out_pkt_nxt;
   wb_pkt_t w_skid_pkt_nxt;
   logic [3:0] w_flags_nxt;

   cond_check u_cond_check (
      .i_cond    (i_cond),
      .i_flags   (r_flags),
      .o_cond_ex (w_cond_ex)
   );

   assign w_acc = i_in_valid && r_in_rdy && !i_flush;
   assign w_deq = r_out_vld && i_out_ready;

   always_comb begin
      w_in_pkt               = '0;
      w_in_pkt.result        = i_result;
      w_in_pkt.ctl.rd        = i_rd;
      w_in_pkt.ctl.reg_write = i_reg_w && w_cond_ex;
      w_in_pkt.ctl.mem_write = i_mem_w && w_cond_ex;
      w_in_pkt.ctl.pcs_src   = i_pcs && w_cond_ex;
      w_in_pkt.ctl.cond_ex   = w_cond_ex;
   end

   // Skid register is only ever occupied while the output register is, so it drains first.
   always_comb begin
      w_out_vld_nxt  = r_out_vld;
      w_out_pkt_nxt  = r_out_pkt;
      w_skid_vld_nxt = r_skid_vld;
      w_skid_pkt_nxt = r_skid_pkt;
      if (i_flush) begin
         w_out_vld_nxt  = 1'b0;
         w_skid_vld_nxt = 1'b0;
      end else if (!r_out_vld || w_deq) begin
         if (r_skid_vld) begin
            w_out_vld_nxt  = 1'b1;
            w_out_pkt_nxt  = r_skid_pkt;
            w_skid_vld_nxt = 1'b0;
         end else begin
            w_out_vld_nxt = w_acc;
            if (w_acc) begin
               w_out_pkt_nxt = w_in_pkt;
            end
         end
      end else if (w_acc) begin
         w_skid_vld_nxt = 1'b1;
         w_skid_pkt_nxt = w_in_pkt;
      end
   end

   always_comb begin
      w_flags_nxt = r_flags;
      if (w_acc && w_cond_ex) begin
         if (i_flag_w[1]) begin
            w_flags_nxt[FLAG_N] = i_n;
            w_flags_nxt[FLAG_Z] = i_z;
         end
         if (i_flag_w[0]) begin
            w_flags_nxt[FLAG_C] = i_c;
            w_flags_nxt[FLAG_V] = i_v;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_out_vld  <= 1'b0;
         r_skid_vld <= 1'b0;
         r_in_rdy   <= 1'b0;
         r_out_pkt  <= '0;
         r_skid_pkt <= '0;
         r_flags    <= 4'b0000;
      end else begin
         r_out_vld  <= w_out_vld_nxt;
         r_skid_vld <= w_skid_vld_nxt;
         r_in_rdy   <= !w_skid_vld_nxt;
         r_out_pkt  <= w_out_pkt_nxt;
         r_skid_pkt <= w_skid_pkt_nxt;
         r_flags    <= w_flags_nxt;
      end
   end

   assign o_in_ready      = r_in_rdy;
   assign o_out_valid     = r_out_vld;
   assign o_out_result    = r_out_pkt.result;
   assign o_out_rd        = r_out_pkt.ctl.rd;
   assign o_out_reg_write = r_out_pkt.ctl.reg_write;
   assign o_out_mem_write = r_out_pkt.ctl.mem_write;
   assign o_out_pcs_src   = r_out_pkt.ctl.pcs_src;
   assign o_out_cond_ex   = r_out_pkt.ctl.cond_ex;
   assign o_flags_q       = r_flags;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: condition table plus handshake, flush and reset sequences.
module tb_alu_result_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] result;
   logic        z, n, v, c;
   logic [3:0]  cond;
   logic [1:0]  flag_w;
   logic        reg_w, mem_w, pcs;
   logic [3:0]  rd;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_result;
   logic [3:0]  out_rd;
   logic        out_reg_write, out_mem_write, out_pcs_src, out_cond_ex;
   logic [3:0]  flags_q;

   int n_checks = 0;
   int n_errors = 0;

   alu_result_stage #(.M(32)) dut (
      .i_clk           (clk),
      .i_rst_n         (rst_n),
      .i_in_valid      (in_valid),
      .o_in_ready      (in_ready),
      .i_result        (result),
      .i_z             (z),
      .i_n             (n),
      .i_v             (v),
      .i_c             (c),
      .i_cond          (cond),
      .i_flag_w        (flag_w),
      .i_reg_w         (reg_w),
      .i_mem_w         (mem_w),
      .i_pcs           (pcs),
      .i_rd            (rd),
      .i_flush         (flush),
      .o_out_valid     (out_valid),
      .i_out_ready     (out_ready),
      .o_out_result    (out_result),
      .o_out_rd        (out_rd),
      .o_out_reg_write (out_reg_write),
      .o_out_mem_write (out_mem_write),
      .o_out_pcs_src   (out_pcs_src),
      .o_out_cond_ex   (out_cond_ex),
      .o_flags_q       (flags_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [3:0] flags;
      logic [3:0] cnd;
      logic       exp;
   } cvec_t;

   cvec_t vecs[19];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] cd, input logic [1:0] fw, input logic [3:0] nzcv,
                        input logic [31:0] res, input logic [3:0] dst, input logic wr);
      cond   = cd;
      flag_w = fw;
      n      = nzcv[3];
      z      = nzcv[2];
      c      = nzcv[1];
      v      = nzcv[0];
      result = res;
      rd     = dst;
      reg_w  = wr;
      mem_w  = wr;
      pcs    = wr;
   endtask

   // Waits (bounded) for in_ready, presents one packet for one edge, then drops in_valid.
   task automatic send(input logic [3:0] cd, input logic [1:0] fw, input logic [3:0] nzcv,
                       input logic [31:0] res, input logic [3:0] dst, input logic wr);
      int b;
      b = 0;
      while (!in_ready && b < 20) begin
         tick();
         b++;
      end
      if (!in_ready) begin
         n_checks++;
         n_errors++;
         $display("FAIL send_wait_ready: got in_ready=0 expected 1 within 20 cycles");
      end
      drive(cd, fw, nzcv, res, dst, wr);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   logic [31:0] got[$];
   logic [3:0]  exp_flags;
   logic        acc;

   initial begin
      vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
      vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
      vecs[2]  = '{4'b0100, 4'b0001, 1'b0};
      vecs[3]  = '{4'b0010, 4'b0010, 1'b1};
      vecs[4]  = '{4'b0010, 4'b0011, 1'b0};
      vecs[5]  = '{4'b1000, 4'b0100, 1'b1};
      vecs[6]  = '{4'b1000, 4'b0101, 1'b0};
      vecs[7]  = '{4'b0001, 4'b0110, 1'b1};
      vecs[8]  = '{4'b0000, 4'b0111, 1'b1};
      vecs[9]  = '{4'b0010, 4'b1000, 1'b1};
      vecs[10] = '{4'b0110, 4'b1000, 1'b0};
      vecs[11] = '{4'b0110, 4'b1001, 1'b1};
      vecs[12] = '{4'b1001, 4'b1010, 1'b1};
      vecs[13] = '{4'b1000, 4'b1011, 1'b1};
      vecs[14] = '{4'b0000, 4'b1100, 1'b1};
      vecs[15] = '{4'b0100, 4'b1100, 1'b0};
      vecs[16] = '{4'b1000, 4'b1101, 1'b1};
      vecs[17] = '{4'b0000, 4'b1110, 1'b1};
      vecs[18] = '{4'b0000, 4'b1111, 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      drive(4'b1110, 2'b00, 4'b0000, 32'h0, 4'h0, 1'b0);

      // Reset state
      #1;
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_flags", {28'b0, flags_q}, 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_enables", {28'b0, out_reg_write, out_mem_write, out_pcs_src, out_cond_ex}, 32'd0);
      chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
      tick();
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready_before_edge", {31'b0, in_ready}, 32'd0);
      tick();
      chk("in_ready_after_edge", {31'b0, in_ready}, 32'd1);

      // AL with flag_w=11, Z=1 C=1
      send(4'b1110, 2'b11, 4'b0110, 32'h0, 4'h1, 1'b1);
      chk("al_out_valid", {31'b0, out_valid}, 32'd1);
      chk("al_cond_ex", {31'b0, out_cond_ex}, 32'd1);
      chk("al_flags", {28'b0, flags_q}, 32'b0110);
      tick();
      chk("al_drained", {31'b0, out_valid}, 32'd0);

      // NE with Z=1 fails: no enables, flags unchanged
      send(4'b0001, 2'b11, 4'b1001, 32'h1234, 4'h2, 1'b1);
      chk("ne_out_valid", {31'b0, out_valid}, 32'd1);
      chk("ne_reg_write", {31'b0, out_reg_write}, 32'd0);
      chk("ne_cond_ex", {31'b0, out_cond_ex}, 32'd0);
      chk("ne_result", out_result, 32'h1234);
      chk("ne_flags", {28'b0, flags_q}, 32'b0110);

      // Back-to-back: second packet sees flags written by the first
      send(4'b1110, 2'b11, 4'b0000, 32'h0, 4'h0, 1'b0);
      chk("b2b_clear_flags", {28'b0, flags_q}, 32'd0);
      drive(4'b1110, 2'b10, 4'b0100, 32'h1, 4'h4, 1'b0);
      in_valid = 1'b1;
      tick();
      chk("b2b_p1_cond_ex", {31'b0, out_cond_ex}, 32'd1);
      drive(4'b0000, 2'b00, 4'b0000, 32'h2, 4'h5, 1'b1);
      tick();
      in_valid = 1'b0;
      chk("b2b_p2_valid", {31'b0, out_valid}, 32'd1);
      chk("b2b_p2_cond_ex", {31'b0, out_cond_ex}, 32'd1);
      chk("b2b_p2_rd", {28'b0, out_rd}, 32'd5);
      chk("b2b_p2_reg_write", {31'b0, out_reg_write}, 32'd1);
      chk("b2b_flags", {28'b0, flags_q}, 32'b0100);

      // Condition table: preset flags, then a packet that tries to invert them
      for (int i = 0; i < 19; i++) begin
         send(4'b1110, 2'b11, vecs[i].flags, 32'h0, 4'h0, 1'b0);
         chk("tbl_preset", {28'b0, flags_q}, {28'b0, vecs[i].flags});
         send(vecs[i].cnd, 2'b11, ~vecs[i].flags, 32'hA0 + i, 4'(i), 1'b1);
         exp_flags = vecs[i].exp ? ~vecs[i].flags : vecs[i].flags;
         chk("tbl_cond_ex", {31'b0, out_cond_ex}, {31'b0, vecs[i].exp});
         chk("tbl_enables", {29'b0, out_reg_write, out_mem_write, out_pcs_src},
             vecs[i].exp ? 32'd7 : 32'd0);
         chk("tbl_result", out_result, 32'hA0 + i);
         chk("tbl_flags", {28'b0, flags_q}, {28'b0, exp_flags});
      end

      // Flush with a buffered packet and an incoming flag-writing packet
      send(4'b1110, 2'b11, 4'b0010, 32'h0, 4'h0, 1'b0);
      out_ready = 1'b0;
      send(4'b1110, 2'b00, 4'b0000, 32'h55, 4'h1, 1'b1);
      chk("fl_buffered", {31'b0, out_valid}, 32'd1);
      drive(4'b1110, 2'b11, 4'b1100, 32'h66, 4'h2, 1'b1);
      in_valid = 1'b1;
      flush    = 1'b1;
      tick();
      in_valid = 1'b0;
      flush    = 1'b0;
      chk("fl_out_valid", {31'b0, out_valid}, 32'd0);
      chk("fl_flags", {28'b0, flags_q}, 32'b0010);
      chk("fl_in_ready", {31'b0, in_ready}, 32'd1);
      tick();
      chk("fl_stays_empty", {31'b0, out_valid}, 32'd0);

      // Stall with three packets, then release and collect in order
      send(4'b1110, 2'b00, 4'b0000, 32'h11, 4'h1, 1'b1);
      chk("st_in_ready_1", {31'b0, in_ready}, 32'd1);
      send(4'b1110, 2'b00, 4'b0000, 32'h22, 4'h2, 1'b1);
      chk("st_in_ready_full", {31'b0, in_ready}, 32'd0);
      chk("st_head", out_result, 32'h11);
      drive(4'b1110, 2'b00, 4'b0000, 32'h33, 4'h3, 1'b1);
      in_valid = 1'b1;
      tick();
      tick();
      chk("st_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("st_hold_result", out_result, 32'h11);
      chk("st_hold_rd", {28'b0, out_rd}, 32'd1);
      chk("st_hold_in_ready", {31'b0, in_ready}, 32'd0);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (out_valid) got.push_back(out_result);
         acc = in_valid && in_ready;
         tick();
         if (acc) in_valid = 1'b0;
      end
      chk("st_count", got.size(), 32'd3);
      if (got.size() == 3) begin
         chk("st_order0", got[0], 32'h11);
         chk("st_order1", got[1], 32'h22);
         chk("st_order2", got[2], 32'h33);
      end

      // Asynchronous reset mid-stall with two entries held
      out_ready = 1'b0;
      send(4'b1110, 2'b00, 4'b0000, 32'h77, 4'h7, 1'b1);
      send(4'b1110, 2'b00, 4'b0000, 32'h88, 4'h8, 1'b1);
      chk("ar_full", {31'b0, in_ready}, 32'd0);
      chk("ar_flags_pre", {28'b0, flags_q}, 32'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_out_valid", {31'b0, out_valid}, 32'd0);
      chk("ar_flags", {28'b0, flags_q}, 32'd0);
      chk("ar_out_result", out_result, 32'd0);
      chk("ar_in_ready", {31'b0, in_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("ar_recover_ready", {31'b0, in_ready}, 32'd1);
      chk("ar_recover_empty", {31'b0, out_valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
